// File: rtl/coreaxitoahbl_pkg.sv
// Shared definitions for the AXI-to-AHB-Lite bridge response path.
// Covers response encodings, the legal RDATA widths and the stall counter width.
package coreaxitoahbl_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int LEGAL_DATA_WIDTH_0 = 32;
  localparam int LEGAL_DATA_WIDTH_1 = 64;
  localparam int LEGAL_DATA_WIDTH_2 = 128;

  localparam int STALLCNT_WIDTH = 16;

  function automatic logic isLegalDataWidth(input int width);
    return (width == LEGAL_DATA_WIDTH_0) ||
           (width == LEGAL_DATA_WIDTH_1) ||
           (width == LEGAL_DATA_WIDTH_2);
  endfunction

endpackage

// File: rtl/coreaxitoahbl_axi_resp_slice_skid.sv
// Two-entry skid buffer: a main register drives the outputs, and a skid register catches one
// extra beat, so o_ready never depends combinationally on i_ready.
module coreaxitoahbl_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_mainValid;
  logic             r_skidValid;
  logic [WIDTH-1:0] r_mainData;
  logic [WIDTH-1:0] r_skidData;
  logic             w_upAccept;
  logic             w_downAccept;

  assign w_upAccept   = i_valid && !r_skidValid;
  assign w_downAccept = r_mainValid && i_ready;

  // A drained main is refilled from skid first, so beats can never overtake each other.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_mainData  <= '0;
      r_skidData  <= '0;
    end else if (w_downAccept) begin
      if (r_skidValid) begin
        r_mainData  <= r_skidData;
        r_skidValid <= 1'b0;
      end else if (w_upAccept) begin
        r_mainData  <= i_data;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_upAccept) begin
      if (!r_mainValid) begin
        r_mainValid <= 1'b1;
        r_mainData  <= i_data;
      end else begin
        r_skidValid <= 1'b1;
        r_skidData  <= i_data;
      end
    end
  end

  assign o_ready = !r_skidValid;
  assign o_valid = r_mainValid;
  assign o_data  = r_mainData;

endmodule

// File: rtl/coreaxitoahbl_axi_resp_slice.sv
// AXI response-side register slice: skid buffers on B and R, and delayed AW/W/AR ready flags.
// Optional read stall counter on RSTALLCNT, enabled by COREAXITOAHBL_RSLICE_STALLCNT_EN.
module coreaxitoahbl_axi_resp_slice
  import coreaxitoahbl_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      AWREADYIn,
  input  logic                      WREADYIn,
  input  logic                      ARREADYIn,
  output logic                      AWREADY,
  output logic                      WREADY,
  output logic                      ARREADY,
  input  logic                      BVALIDIn,
  input  logic [1:0]                BRESPIn,
  input  logic [ID_WIDTH-1:0]       BIDIn,
  output logic                      BREADYIn,
  output logic                      BVALID,
  output logic [1:0]                BRESP,
  output logic [ID_WIDTH-1:0]       BID,
  input  logic                      BREADY,
  input  logic                      RVALIDIn,
  input  logic                      RLASTIn,
  input  logic [DATA_WIDTH-1:0]     RDATAIn,
  input  logic [ID_WIDTH-1:0]       RIDIn,
  input  logic [1:0]                RRESPIn,
  output logic                      RREADYIn,
  output logic                      RVALID,
  output logic                      RLAST,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [ID_WIDTH-1:0]       RID,
  output logic [1:0]                RRESP,
  input  logic                      RREADY
`ifdef COREAXITOAHBL_RSLICE_STALLCNT_EN
  ,
  output logic [STALLCNT_WIDTH-1:0] RSTALLCNT
`endif
);

  localparam int B_WIDTH = ID_WIDTH + 2;
  localparam int R_WIDTH = ID_WIDTH + 2 + DATA_WIDTH + 1;

  if (!isLegalDataWidth(DATA_WIDTH)) begin : g_badDataWidth
    $error("coreaxitoahbl_axi_resp_slice: DATA_WIDTH must be 32, 64 or 128");
  end

  logic               r_awReady;
  logic               r_wReady;
  logic               r_arReady;
  logic [B_WIDTH-1:0] w_bIn;
  logic [B_WIDTH-1:0] w_bOut;
  logic [R_WIDTH-1:0] w_rIn;
  logic [R_WIDTH-1:0] w_rOut;

  // The ready flags are pure one-cycle delays; the controller owns their handshake meaning.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awReady <= 1'b0;
      r_wReady  <= 1'b0;
      r_arReady <= 1'b0;
    end else begin
      r_awReady <= AWREADYIn;
      r_wReady  <= WREADYIn;
      r_arReady <= ARREADYIn;
    end
  end

  assign AWREADY = r_awReady;
  assign WREADY  = r_wReady;
  assign ARREADY = r_arReady;

  assign w_bIn = {BIDIn, BRESPIn};

  coreaxitoahbl_skid_slice #(
    .WIDTH (B_WIDTH)
  ) u_bSlice (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .i_valid (BVALIDIn),
    .i_data  (w_bIn),
    .o_ready (BREADYIn),
    .o_valid (BVALID),
    .o_data  (w_bOut),
    .i_ready (BREADY)
  );

  assign {BID, BRESP} = w_bOut;

  assign w_rIn = {RIDIn, RRESPIn, RDATAIn, RLASTIn};

  coreaxitoahbl_skid_slice #(
    .WIDTH (R_WIDTH)
  ) u_rSlice (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .i_valid (RVALIDIn),
    .i_data  (w_rIn),
    .o_ready (RREADYIn),
    .o_valid (RVALID),
    .o_data  (w_rOut),
    .i_ready (RREADY)
  );

  assign {RID, RRESP, RDATA, RLAST} = w_rOut;

`ifdef COREAXITOAHBL_RSLICE_STALLCNT_EN
  logic [STALLCNT_WIDTH-1:0] r_stallCnt;

  // Counts cycles the master holds off a valid read beat; sticks at all-ones.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_stallCnt <= '0;
    end else if (RVALID && !RREADY && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + STALLCNT_WIDTH'(1);
    end
  end

  assign RSTALLCNT = r_stallCnt;
`endif

endmodule

// File: tb/tb_coreaxitoahbl_axi_resp_slice.sv
// Directed self-checking bench for coreaxitoahbl_axi_resp_slice.
// Stall counter checks are built only when COREAXITOAHBL_RSLICE_STALLCNT_EN is defined.
module tb_coreaxitoahbl_axi_resp_slice;
  import coreaxitoahbl_pkg::*;

  localparam int ID_WIDTH   = 4;
  localparam int DATA_WIDTH = 64;

  logic                  ACLK = 1'b0;
  logic                  ARESETN;
  logic                  AWREADYIn, WREADYIn, ARREADYIn;
  logic                  AWREADY, WREADY, ARREADY;
  logic                  BVALIDIn;
  logic [1:0]            BRESPIn;
  logic [ID_WIDTH-1:0]   BIDIn;
  logic                  BREADYIn;
  logic                  BVALID;
  logic [1:0]            BRESP;
  logic [ID_WIDTH-1:0]   BID;
  logic                  BREADY;
  logic                  RVALIDIn, RLASTIn;
  logic [DATA_WIDTH-1:0] RDATAIn;
  logic [ID_WIDTH-1:0]   RIDIn;
  logic [1:0]            RRESPIn;
  logic                  RREADYIn;
  logic                  RVALID, RLAST;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [ID_WIDTH-1:0]   RID;
  logic [1:0]            RRESP;
  logic                  RREADY;
`ifdef COREAXITOAHBL_RSLICE_STALLCNT_EN
  logic [STALLCNT_WIDTH-1:0] RSTALLCNT;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 ACLK = ~ACLK;

  coreaxitoahbl_axi_resp_slice #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .AWREADYIn (AWREADYIn),
    .WREADYIn  (WREADYIn),
    .ARREADYIn (ARREADYIn),
    .AWREADY   (AWREADY),
    .WREADY    (WREADY),
    .ARREADY   (ARREADY),
    .BVALIDIn  (BVALIDIn),
    .BRESPIn   (BRESPIn),
    .BIDIn     (BIDIn),
    .BREADYIn  (BREADYIn),
    .BVALID    (BVALID),
    .BRESP     (BRESP),
    .BID       (BID),
    .BREADY    (BREADY),
    .RVALIDIn  (RVALIDIn),
    .RLASTIn   (RLASTIn),
    .RDATAIn   (RDATAIn),
    .RIDIn     (RIDIn),
    .RRESPIn   (RRESPIn),
    .RREADYIn  (RREADYIn),
    .RVALID    (RVALID),
    .RLAST     (RLAST),
    .RDATA     (RDATA),
    .RID       (RID),
    .RRESP     (RRESP),
    .RREADY    (RREADY)
`ifdef COREAXITOAHBL_RSLICE_STALLCNT_EN
    ,
    .RSTALLCNT (RSTALLCNT)
`endif
  );

  // All tasks start and end just after a falling edge; inputs change there, outputs are sampled there.
  task automatic test_reset;
    ARESETN = 1'b0;
    AWREADYIn = 0; WREADYIn = 0; ARREADYIn = 0;
    BVALIDIn = 0; BRESPIn = 0; BIDIn = 0; BREADY = 0;
    RVALIDIn = 0; RLASTIn = 0; RDATAIn = 0; RIDIn = 0; RRESPIn = 0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checkCount++;
    if ({AWREADY, WREADY, ARREADY, BVALID, BRESP, BID} !== '0)
      $display("[TB] FAIL reset_b_ready: got %b expected 0", {AWREADY, WREADY, ARREADY, BVALID, BRESP, BID});
    else passCount++;
    checkCount++;
    if ({RVALID, RLAST, RDATA, RID, RRESP} !== '0)
      $display("[TB] FAIL reset_r: got valid=%b data=%h expected 0", RVALID, RDATA);
    else passCount++;
    checkCount++;
    if ({BREADYIn, RREADYIn} !== 2'b11)
      $display("[TB] FAIL reset_readyin: got %b expected 11", {BREADYIn, RREADYIn});
    else passCount++;
  endtask

  task automatic test_ready_flops;
    AWREADYIn = 1; WREADYIn = 0; ARREADYIn = 1;
    checkCount++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000)
      $display("[TB] FAIL ready_pre_edge: got %b expected 000", {AWREADY, WREADY, ARREADY});
    else passCount++;
    @(negedge ACLK);
    checkCount++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b101)
      $display("[TB] FAIL ready_101: got %b expected 101", {AWREADY, WREADY, ARREADY});
    else passCount++;
    AWREADYIn = 0; WREADYIn = 1; ARREADYIn = 0;
    @(negedge ACLK);
    checkCount++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b010)
      $display("[TB] FAIL ready_010: got %b expected 010", {AWREADY, WREADY, ARREADY});
    else passCount++;
    WREADYIn = 0;
    @(negedge ACLK);
  endtask

  task automatic test_read_burst;
    RREADY = 1; RVALIDIn = 1; RDATAIn = 64'h1; RLASTIn = 0; RIDIn = 4'h3; RRESPIn = OKAY;
    for (int i = 1; i <= 8; i++) begin
      @(negedge ACLK);
      checkCount++;
      if (RVALID !== 1'b1 || RDATA !== 64'(i) || RLAST !== (i == 8) || RID !== 4'h3)
        $display("[TB] FAIL burst_beat%0d: got v=%b d=%h l=%b id=%h expected v=1 d=%h l=%b id=3",
                 i, RVALID, RDATA, RLAST, RID, 64'(i), (i == 8));
      else passCount++;
      if (i < 8) begin
        RDATAIn = 64'(i + 1);
        RLASTIn = (i + 1 == 8);
      end else begin
        RVALIDIn = 0; RLASTIn = 0;
      end
    end
    @(negedge ACLK);
    checkCount++;
    if (RVALID !== 1'b0)
      $display("[TB] FAIL burst_end: got RVALID=%b expected 0", RVALID);
    else passCount++;
    checkCount++;
    if (BVALID !== 1'b0)
      $display("[TB] FAIL burst_b_idle: got BVALID=%b expected 0", BVALID);
    else passCount++;
  endtask

  task automatic test_read_backpressure;
    int sent = 0;
    int nRx  = 0;
    for (int c = 1; c <= 40; c++) begin
      RREADY = !(c >= 2 && c <= 5);
      if (sent < 8) begin
        RVALIDIn = 1;
        RDATAIn  = 64'(sent + 1);
        RLASTIn  = (sent + 1 == 8);
      end else begin
        RVALIDIn = 0; RLASTIn = 0;
      end
      if (c >= 3 && c <= 5) begin
        checkCount++;
        if (RVALID !== 1'b1 || RDATA !== 64'h1 || RREADYIn !== 1'b0)
          $display("[TB] FAIL bp_hold_c%0d: got v=%b d=%h rdyIn=%b expected v=1 d=1 rdyIn=0",
                   c, RVALID, RDATA, RREADYIn);
        else passCount++;
      end
      if (RVALID && RREADY) begin
        nRx++;
        checkCount++;
        if (RDATA !== 64'(nRx) || RLAST !== (nRx == 8))
          $display("[TB] FAIL bp_order%0d: got d=%h l=%b expected d=%h l=%b",
                   nRx, RDATA, RLAST, 64'(nRx), (nRx == 8));
        else passCount++;
      end
      if (RVALIDIn && RREADYIn) sent++;
      @(negedge ACLK);
    end
    checkCount++;
    if (nRx !== 8)
      $display("[TB] FAIL bp_count: got %0d beats expected 8", nRx);
    else passCount++;
  endtask

  task automatic test_write_resp;
    BVALIDIn = 1; BIDIn = 4'hA; BRESPIn = SLVERR; BREADY = 0;
    @(negedge ACLK);
    BVALIDIn = 0; BIDIn = 0; BRESPIn = 0;
    for (int k = 0; k < 4; k++) begin
      checkCount++;
      if (BVALID !== 1'b1 || BID !== 4'hA || BRESP !== 2'b10)
        $display("[TB] FAIL b_hold%0d: got v=%b id=%h resp=%b expected v=1 id=a resp=10",
                 k, BVALID, BID, BRESP);
      else passCount++;
      if (k == 3) BREADY = 1;
      @(negedge ACLK);
    end
    checkCount++;
    if (BVALID !== 1'b0)
      $display("[TB] FAIL b_drain: got BVALID=%b expected 0", BVALID);
    else passCount++;
  endtask

  task automatic test_reset_midburst;
    RREADY = 0; RVALIDIn = 1; RDATAIn = 64'h11; RLASTIn = 0;
    @(negedge ACLK);
    RDATAIn = 64'h22;
    @(negedge ACLK);
    RVALIDIn = 0;
    checkCount++;
    if (RVALID !== 1'b1 || RREADYIn !== 1'b0)
      $display("[TB] FAIL mid_full: got v=%b rdyIn=%b expected v=1 rdyIn=0", RVALID, RREADYIn);
    else passCount++;
    #2 ARESETN = 0;
    #1;
    checkCount++;
    if (RVALID !== 1'b0 || RREADYIn !== 1'b1 || RDATA !== '0)
      $display("[TB] FAIL mid_async: got v=%b rdyIn=%b d=%h expected v=0 rdyIn=1 d=0",
               RVALID, RREADYIn, RDATA);
    else passCount++;
    @(negedge ACLK);
    ARESETN = 1; RREADY = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      checkCount++;
      if (RVALID !== 1'b0)
        $display("[TB] FAIL mid_stale%0d: got RVALID=%b expected 0", k, RVALID);
      else passCount++;
    end
  endtask

`ifdef COREAXITOAHBL_RSLICE_STALLCNT_EN
  task automatic test_stall_counter;
    checkCount++;
    if (RSTALLCNT !== 16'h0)
      $display("[TB] FAIL stall_init: got %h expected 0000", RSTALLCNT);
    else passCount++;
    RREADY = 0; RVALIDIn = 1; RDATAIn = 64'h55;
    @(negedge ACLK);
    RVALIDIn = 0;
    repeat (5) @(negedge ACLK);
    checkCount++;
    if (RSTALLCNT !== 16'd5)
      $display("[TB] FAIL stall_5: got %0d expected 5", RSTALLCNT);
    else passCount++;
    repeat (70000) @(negedge ACLK);
    checkCount++;
    if (RSTALLCNT !== 16'hFFFF)
      $display("[TB] FAIL stall_sat: got %h expected ffff", RSTALLCNT);
    else passCount++;
    RREADY = 1;
    @(negedge ACLK);
    checkCount++;
    if (RVALID !== 1'b0 || RSTALLCNT !== 16'hFFFF)
      $display("[TB] FAIL stall_drain: got v=%b cnt=%h expected v=0 cnt=ffff", RVALID, RSTALLCNT);
    else passCount++;
  endtask
`endif

  initial begin
    test_reset();
    test_ready_flops();
    test_read_burst();
    test_read_backpressure();
    test_write_resp();
    test_reset_midburst();
`ifdef COREAXITOAHBL_RSLICE_STALLCNT_EN
    test_stall_counter();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/coreaxitoahbl_axi_resp_slice.md
# coreaxitoahbl_axi_resp_slice

Parametrised AXI response-side register slice sitting between the AXI slave controller and the AXI master port of the AXI-to-AHB-Lite bridge. B and R channels each get a two-entry skid buffer, so every output is registered while downstream BREADY/RREADY backpressure is honoured at full throughput. AWREADY/WREADY/ARREADY are delayed by one flop, as in the existing output stage. DATA_WIDTH and ID_WIDTH are generic.

## Interface
- ID_WIDTH, 4, width of BID/RID.
- DATA_WIDTH, 64, width of RDATA; legal values are 32, 64 and 128.
- ACLK  input  1  clock; all state changes on the rising edge.
- ARESETN  input  1  reset, asynchronous, active-low.
- AWREADYIn, WREADYIn, ARREADYIn  input  1 each  ready flags from the controller.
- AWREADY, WREADY, ARREADY  output  1 each  registered copies of the ready flags.
- BVALIDIn  input  1  write response valid from the controller.
- BRESPIn  input  2  write response code.
- BIDIn  input  ID_WIDTH  write response ID.
- BREADYIn  output  1  slice can accept a write response.
- BVALID, BRESP, BID  output  1/2/ID_WIDTH  registered write response to the master.
- BREADY  input  1  master accepts the write response.
- RVALIDIn, RLASTIn  input  1 each  read beat valid and last flag.
- RDATAIn  input  DATA_WIDTH  read data.
- RIDIn  input  ID_WIDTH  read ID.
- RRESPIn  input  2  read response code.
- RREADYIn  output  1  slice can accept a read beat.
- RVALID, RLAST, RDATA, RID, RRESP  output  1/1/DATA_WIDTH/ID_WIDTH/2  registered read beat.
- RREADY  input  1  master accepts the read beat.
- RSTALLCNT  output  16  read stall counter; present only with the Configuration macro.

## Operation
- Each channel (B, R) is an identical skid slice with payload {ID, RESP[, DATA, LAST]}.
- Each slice holds a main register (drives the outputs) and a skid register, each with its own valid bit.
- Upstream accept = xVALIDIn && xREADYIn.
- Downstream accept = xVALID && xREADY.
- xREADYIn = !skid_valid. It is a registered term, with no combinational path from xREADY.
- Upstream accept, main empty or main being drained this cycle, skid empty: load main.
- Upstream accept, main full and not drained: load skid.
- Downstream accept with skid full: skid moves to main and skid clears.
- Downstream accept with no new data and skid empty: main valid clears.
- Ordering is strictly FIFO. Payload is never modified; RLAST passes through untouched.
- Payload is held stable while xVALID=1 and xREADY=0 (AXI rule).
- AWREADY/WREADY/ARREADY = xREADYIn sampled one cycle earlier. They carry no handshake logic.
- B and R slices run fully independently. Simultaneous activity on both has no interaction.

## Timing
- Reset values: all outputs 0, except BREADYIn=1 and RREADYIn=1. Both valid bits clear; RSTALLCNT=0.
- Reset asserted mid-transfer discards buffered beats immediately (asynchronous). No partial beat is emitted after release.
- Latency: 1 cycle from input accept to output valid.
- Throughput: 1 beat/cycle sustained with xREADY held 1.
- Full: two beats buffered, xREADYIn=0 in the cycle after the second accept.
- xREADYIn returns to 1 in the cycle after the first downstream accept that empties the skid.
- Upstream accept and downstream accept in the same cycle with skid empty: main is replaced, valid stays 1, occupancy is unchanged.

## Configuration
- COREAXITOAHBL_RSLICE_STALLCNT_EN defined: RSTALLCNT port exists and increments on each cycle with RVALID=1 and RREADY=0. It saturates at 16'hFFFF and is cleared only by reset.
- Macro undefined: no port and no counter logic. Slice behaviour is otherwise identical.

## Structure
- Shared package coreaxitoahbl_pkg holds:
  - BRESP/RRESP encodings (OKAY=2'b00, SLVERR=2'b10).
  - the legal DATA_WIDTH list.
  - STALLCNT_WIDTH=16.
- One sub-module, coreaxitoahbl_skid_slice, parametrised by payload width and instantiated twice (B, R).
- The top level packs and unpacks the payload vectors and holds the three ready flops.

## Test plan
- Reset release, idle inputs -> all outputs 0, BREADYIn=RREADYIn=1, first cycle after release.
- 8-beat read, RDATAIn=0x1..0x8, RLASTIn on beat 8, RREADY=1 -> RDATA 0x1..0x8 on consecutive cycles starting 1 cycle later, RLAST only with 0x8, no bubbles.
- Same burst with RREADY=0 for cycles 2-5 -> RREADYIn drops after 2 beats buffered; output holds 0x1 stable; after release all 8 beats are delivered in order, none lost or duplicated.
- BVALIDIn pulse, BID=4'hA, BRESP=2'b10, BREADY=0 for 3 cycles -> BVALID=1 held with BID=A and BRESP=10 until the BREADY cycle, then BVALID=0.
- ARESETN pulsed low with 2 R beats buffered -> RVALID=0 immediately; no stale beat after release.
- With the macro defined, RVALID=1 and RREADY=0 for 5 cycles -> RSTALLCNT=5; forced 70000 stall cycles -> RSTALLCNT=16'hFFFF.
